fft_butterfly_pipe: RTL and testbench

- Pipelined, parametrised radix-2 DIT butterfly for the tuner FFT core; drop-in successor to the combinational butterfly.
- Computes aout = a + b·w and bout = a − b·w on packed complex fixed-point samples, with a fixed latency of 3 cycles.
- Adds valid/ready flow control with backpressure, an inverse-FFT mode (conjugate twiddle), optional per-stage ÷2 scaling, round-to-nearest, saturation, and overflow reporting.

---
 rtl/fft_butterfly_pipe_if.sv | 35 +++
 rtl/fft_butterfly_pipe.sv | 186 ++++++++++++++++++
 tb/tb_fft_butterfly_pipe.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fft_butterfly_pipe_if.sv
// Purpose : stream bundle for fft_butterfly_pipe (input beat, output beat, overflow control).
// Latency : none; wiring only.
// Backpressure: in_ready/out_ready carry stalls; signals are plain nets.
//
// Ports (via modports):
//   master : drives in_valid, a, b, twiddle, inverse, scale, out_ready, ovf_clr
//   slave  : drives in_ready, out_valid, aout, bout, out_sat, ovf_sticky
interface fft_butterfly_pipe_if #(
  parameter int W = 16
);
  logic            in_valid;
  logic            in_ready;
  logic [2*W-1:0]  a;
  logic [2*W-1:0]  b;
  logic [2*W-1:0]  twiddle;
  logic            inverse;
  logic            scale;
  logic            out_valid;
  logic            out_ready;
  logic [2*W-1:0]  aout;
  logic [2*W-1:0]  bout;
  logic            out_sat;
  logic            ovf_sticky;
  logic            ovf_clr;

  modport master (
    output in_valid, a, b, twiddle, inverse, scale, out_ready, ovf_clr,
    input  in_ready, out_valid, aout, bout, out_sat, ovf_sticky
  );

  modport slave (
    input  in_valid, a, b, twiddle, inverse, scale, out_ready, ovf_clr,
    output in_ready, out_valid, aout, bout, out_sat, ovf_sticky
  );
endinterface

// File: rtl/fft_butterfly_pipe.sv
// Purpose : pipelined radix-2 DIT butterfly, aout = a + b*w, bout = a - b*w (conj(w) when inverse).
// Latency : 3 cycles from input transfer to out_valid, 1 beat/cycle throughput.
// Backpressure: whole pipe freezes while out_valid & ~out_ready; in_ready = ~stall (combinational).
//
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   bus        : slave side of fft_butterfly_pipe_if; samples packed {re, im} in Q1.(W-1),
//                inverse/scale travel with the beat, out_sat flags a clipped beat,
//                ovf_sticky latches any transferred clipped beat until ovf_clr.
module fft_butterfly_pipe #(
  parameter int W = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  fft_butterfly_pipe_if.slave   bus
);

  localparam int PW = 2 * W;
  // Half an LSB of the rounded result, added before dropping W-1 fraction bits.
  localparam logic signed [PW:0] RND = (PW+1)'(2 ** (W - 2));

  // ------------------------------------------------------------------
  // Flow control: a single global enable; no internal bubbles are squeezed,
  // the stage valids simply travel with their data.
  // ------------------------------------------------------------------
  logic stall;
  logic adv;
  logic v1, v2, v3;

  assign stall         = v3 & ~bus.out_ready;
  assign adv           = ~stall;
  assign bus.in_ready  = adv;
  assign bus.out_valid = v3;

  // ------------------------------------------------------------------
  // S1: four real partial products
  // ------------------------------------------------------------------
  logic signed [W-1:0] b_re, b_im, w_re, w_im;

  assign b_re = bus.b[PW-1:W];
  assign b_im = bus.b[W-1:0];
  assign w_re = bus.twiddle[PW-1:W];
  assign w_im = bus.twiddle[W-1:0];

  logic signed [PW-1:0] m_rr, m_ii, m_ri, m_ir;
  logic [PW-1:0]        a1;
  logic                 inv1, scl1;

  always_ff @(posedge clk) begin
    if (reset) begin
      v1   <= 1'b0;
      m_rr <= '0;
      m_ii <= '0;
      m_ri <= '0;
      m_ir <= '0;
      a1   <= '0;
      inv1 <= 1'b0;
      scl1 <= 1'b0;
    end else if (adv) begin
      v1   <= bus.in_valid;
      m_rr <= PW'(b_re) * PW'(w_re);
      m_ii <= PW'(b_im) * PW'(w_im);
      m_ri <= PW'(b_re) * PW'(w_im);
      m_ir <= PW'(b_im) * PW'(w_re);
      a1   <= bus.a;
      inv1 <= bus.inverse;
      scl1 <= bus.scale;
    end
  end

  // ------------------------------------------------------------------
  // S2: complex product, round to nearest, keep W+1 bits (no clipping yet;
  // the extra integer bit is needed because |b*w| can reach ~2).
  // ------------------------------------------------------------------
  logic signed [PW:0] pr_sum, pi_sum, pr_rnd, pi_rnd;

  always_comb begin
    pr_sum = '0;
    pi_sum = '0;
    if (inv1) begin
      pr_sum = (PW+1)'(m_rr) + (PW+1)'(m_ii);
      pi_sum = (PW+1)'(m_ir) - (PW+1)'(m_ri);
    end else begin
      pr_sum = (PW+1)'(m_rr) - (PW+1)'(m_ii);
      pi_sum = (PW+1)'(m_ri) + (PW+1)'(m_ir);
    end
  end

  assign pr_rnd = pr_sum + RND;
  assign pi_rnd = pi_sum + RND;

  // The arithmetic shift by W-1 followed by truncation to W+1 bits is just
  // the bit window [PW-1:W-1]; the remaining bits are intentionally dropped.
  logic unused_rnd_bits;
  assign unused_rnd_bits = ^{pr_rnd[PW], pr_rnd[W-2:0], pi_rnd[PW], pi_rnd[W-2:0]};

  logic signed [W:0] t2_re, t2_im;
  logic [PW-1:0]     a2;
  logic              scl2;

  always_ff @(posedge clk) begin
    if (reset) begin
      v2    <= 1'b0;
      t2_re <= '0;
      t2_im <= '0;
      a2    <= '0;
      scl2  <= 1'b0;
    end else if (adv) begin
      v2    <= v1;
      t2_re <= pr_rnd[PW-1:W-1];
      t2_im <= pi_rnd[PW-1:W-1];
      a2    <= a1;
      scl2  <= scl1;
    end
  end

  // ------------------------------------------------------------------
  // S3: butterfly sums at W+2 bits, optional rounded halving, clipping
  // ------------------------------------------------------------------
  function automatic logic signed [W+1:0] halve(input logic signed [W+1:0] s, input logic en);
    logic signed [W+1:0] r;
    r = s + (W+2)'(1);
    return en ? (r >>> 1) : s;
  endfunction

  // Returns {clipped, value}; in range when the top three bits agree.
  function automatic logic [W:0] clip(input logic signed [W+1:0] s);
    if (s[W+1:W-1] == 3'b000 || s[W+1:W-1] == 3'b111)
      return {1'b0, s[W-1:0]};
    else if (s[W+1])
      return {1'b1, 1'b1, {(W-1){1'b0}}};
    else
      return {1'b1, 1'b0, {(W-1){1'b1}}};
  endfunction

  logic signed [W-1:0] a2_re, a2_im;
  logic signed [W+1:0] sa_re, sa_im, sb_re, sb_im;
  logic [W:0]          ca_re, ca_im, cb_re, cb_im;

  assign a2_re = a2[PW-1:W];
  assign a2_im = a2[W-1:0];

  assign sa_re = halve((W+2)'(a2_re) + (W+2)'(t2_re), scl2);
  assign sa_im = halve((W+2)'(a2_im) + (W+2)'(t2_im), scl2);
  assign sb_re = halve((W+2)'(a2_re) - (W+2)'(t2_re), scl2);
  assign sb_im = halve((W+2)'(a2_im) - (W+2)'(t2_im), scl2);

  assign ca_re = clip(sa_re);
  assign ca_im = clip(sa_im);
  assign cb_re = clip(sb_re);
  assign cb_im = clip(sb_im);

  logic [PW-1:0] aout_q, bout_q;
  logic          sat_q;
  logic          sticky_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      v3     <= 1'b0;
      aout_q <= '0;
      bout_q <= '0;
      sat_q  <= 1'b0;
    end else if (adv) begin
      v3     <= v2;
      aout_q <= {ca_re[W-1:0], ca_im[W-1:0]};
      bout_q <= {cb_re[W-1:0], cb_im[W-1:0]};
      sat_q  <= ca_re[W] | ca_im[W] | cb_re[W] | cb_im[W];
    end
  end

  // A clipped beat leaving the block outranks a simultaneous clear.
  always_ff @(posedge clk) begin
    if (reset)
      sticky_q <= 1'b0;
    else if (v3 & bus.out_ready & sat_q)
      sticky_q <= 1'b1;
    else if (bus.ovf_clr)
      sticky_q <= 1'b0;
  end

  assign bus.aout       = aout_q;
  assign bus.bout       = bout_q;
  assign bus.out_sat    = sat_q;
  assign bus.ovf_sticky = sticky_q;

endmodule

// File: tb/tb_fft_butterfly_pipe.sv
module tb_fft_butterfly_pipe;

  localparam int W = 16;

  logic clk;
  logic reset;

  fft_butterfly_pipe_if #(.W(W)) bus ();

  fft_butterfly_pipe #(.W(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int n_out = 0;

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b, expected %b", nm, act, exp);
    end
  endtask

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // ------------------------------------------------------------------
  // Reference: plain integer arithmetic on the butterfly equations.
  // Result packing: {sat, aout[31:0], bout[31:0]}.
  // ------------------------------------------------------------------
  function automatic longint wrap17(input longint v);
    longint r;
    r = v & 64'h1FFFF;
    if (r >= 65536) r = r - 131072;
    return r;
  endfunction

  function automatic logic [64:0] model(input logic [31:0] a, b, tw, input logic inv, scl);
    longint ar, ai, br, bi, tr, ti, pr, pi, xr, xi;
    longint s[4];
    logic [15:0] o[4];
    logic sat;
    ar = longint'($signed(a[31:16]));
    ai = longint'($signed(a[15:0]));
    br = longint'($signed(b[31:16]));
    bi = longint'($signed(b[15:0]));
    tr = longint'($signed(tw[31:16]));
    ti = longint'($signed(tw[15:0]));
    if (inv) begin
      pr = br * tr + bi * ti;
      pi = bi * tr - br * ti;
    end else begin
      pr = br * tr - bi * ti;
      pi = br * ti + bi * tr;
    end
    xr = wrap17((pr + 16384) >>> 15);
    xi = wrap17((pi + 16384) >>> 15);
    s[0] = ar + xr;
    s[1] = ai + xi;
    s[2] = ar - xr;
    s[3] = ai - xi;
    sat = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (scl) s[k] = (s[k] + 1) >>> 1;
      if (s[k] > 32767) begin
        s[k] = 32767;
        sat = 1'b1;
      end else if (s[k] < -32768) begin
        s[k] = -32768;
        sat = 1'b1;
      end
      o[k] = 16'(s[k]);
    end
    return {sat, o[0], o[1], o[2], o[3]};
  endfunction

  // ------------------------------------------------------------------
  // Scoreboard / compare process, sampled on the falling edge.
  // ------------------------------------------------------------------
  logic [64:0] sb_q[$];
  logic [64:0] sb_e;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_aout, prev_bout;
  logic        prev_sat;

  always @(negedge clk) begin
    if (reset) begin
      sb_q.delete();
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk32("hold_aout", bus.aout, prev_aout);
        chk32("hold_bout", bus.bout, prev_bout);
        chk1("hold_sat", bus.out_sat, prev_sat);
      end
      if (bus.out_valid && bus.out_ready) begin
        if (sb_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL sb_spurious: got output %h/%h, expected none", bus.aout, bus.bout);
        end else begin
          sb_e = sb_q.pop_front();
          chk32("sb_aout", bus.aout, sb_e[63:32]);
          chk32("sb_bout", bus.bout, sb_e[31:0]);
          chk1("sb_sat", bus.out_sat, sb_e[64]);
          n_out++;
        end
      end
      if (bus.in_valid && bus.in_ready)
        sb_q.push_back(model(bus.a, bus.b, bus.twiddle, bus.inverse, bus.scale));
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_aout  = bus.aout;
      prev_bout  = bus.bout;
      prev_sat   = bus.out_sat;
    end
  end

  // ------------------------------------------------------------------
  // Stimulus helpers
  // ------------------------------------------------------------------
  task automatic drive(input logic [31:0] a, b, tw, input logic inv, scl);
    bus.a       = a;
    bus.b       = b;
    bus.twiddle = tw;
    bus.inverse = inv;
    bus.scale   = scl;
  endtask

  // One isolated beat; checks latency 3 and the literal results.
  task automatic one_beat(input string nm, input logic [31:0] a, b, tw, input logic inv, scl,
                          input logic [31:0] ea, eb, input logic es);
    @(posedge clk); #1;
    drive(a, b, tw, inv, scl);
    bus.in_valid = 1'b1;
    @(negedge clk);
    chk1({nm, "_in_ready"}, bus.in_ready, 1'b1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk1({nm, "_lat1"}, bus.out_valid, 1'b0);
    @(negedge clk);
    chk1({nm, "_lat2"}, bus.out_valid, 1'b0);
    @(negedge clk);
    chk1({nm, "_lat3"}, bus.out_valid, 1'b1);
    chk32({nm, "_aout"}, bus.aout, ea);
    chk32({nm, "_bout"}, bus.bout, eb);
    chk1({nm, "_sat"}, bus.out_sat, es);
  endtask

  logic [31:0] sa[5], sbv[5], stw[5];
  logic        sinv[5], sscl[5];

  initial begin
    sa[0] = 32'h1000_2000; sbv[0] = 32'h0800_F800; stw[0] = 32'h5A82_A57E; sinv[0] = 0; sscl[0] = 0;
    sa[1] = 32'h7000_9000; sbv[1] = 32'h4000_4000; stw[1] = 32'h7FFF_0000; sinv[1] = 0; sscl[1] = 1;
    sa[2] = 32'h8000_8000; sbv[2] = 32'h7FFF_7FFF; stw[2] = 32'h5A82_5A82; sinv[2] = 1; sscl[2] = 0;
    sa[3] = 32'h0123_4567; sbv[3] = 32'h89AB_CDEF; stw[3] = 32'h3000_D000; sinv[3] = 1; sscl[3] = 1;
    sa[4] = 32'hF000_0F00; sbv[4] = 32'h1234_ABCD; stw[4] = 32'h8000_0000; sinv[4] = 0; sscl[4] = 0;
  end

  // ------------------------------------------------------------------
  // Main sequence
  // ------------------------------------------------------------------
  initial begin
    int base;
    logic [31:0] held_a, held_b;

    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    bus.ovf_clr   = 1'b0;
    drive(32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    @(negedge clk);
    chk1("rst_out_valid", bus.out_valid, 1'b0);
    chk1("rst_out_sat", bus.out_sat, 1'b0);
    chk1("rst_sticky", bus.ovf_sticky, 1'b0);
    chk32("rst_aout", bus.aout, 32'h0);
    chk32("rst_bout", bus.bout, 32'h0);
    chk1("rst_in_ready", bus.in_ready, 1'b1);

    one_beat("fwd_id", 32'h4000_2000, 32'h2000_E000, 32'h7FFF_0000, 0, 0,
             32'h6000_0000, 32'h2000_4000, 0);
    one_beat("fwd_j", 32'hE000_6000, 32'h0CCD_199A, 32'h0000_7FFF, 0, 0,
             32'hC666_6CCD, 32'hF99A_5333, 0);
    one_beat("inv_j", 32'hE000_6000, 32'h0CCD_199A, 32'h0000_7FFF, 1, 0,
             32'hF99A_5333, 32'hC666_6CCD, 0);

    one_beat("sat", 32'h7FFF_0000, 32'h7FFF_0000, 32'h7FFF_0000, 0, 0,
             32'h7FFF_0000, 32'h0001_0000, 1);
    @(negedge clk);
    chk1("sticky_set", bus.ovf_sticky, 1'b1);
    @(posedge clk); #1 bus.ovf_clr = 1'b1;
    @(posedge clk); #1 bus.ovf_clr = 1'b0;
    @(negedge clk);
    chk1("sticky_clr", bus.ovf_sticky, 1'b0);

    one_beat("scaled", 32'h7FFF_0000, 32'h7FFF_0000, 32'h7FFF_0000, 0, 1,
             32'h7FFF_0000, 32'h0001_0000, 0);
    @(negedge clk);
    chk1("sticky_scaled", bus.ovf_sticky, 1'b0);

    // Clear requested in the very cycle a clipped beat transfers.
    one_beat("setwins", 32'h7FFF_0000, 32'h7FFF_0000, 32'h7FFF_0000, 0, 0,
             32'h7FFF_0000, 32'h0001_0000, 1);
    bus.ovf_clr = 1'b1;
    @(posedge clk); #1 bus.ovf_clr = 1'b0;
    @(negedge clk);
    chk1("sticky_setwins", bus.ovf_sticky, 1'b1);

    // Backpressure: 5 back-to-back beats, output stalled 4 cycles.
    base = n_out;
    fork
      begin
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) begin
          int  g;
          logic acc;
          drive(sa[i], sbv[i], stw[i], sinv[i], sscl[i]);
          bus.in_valid = 1'b1;
          g = 0;
          do begin
            @(negedge clk);
            acc = bus.in_ready;
            @(posedge clk); #1;
            g++;
          end while (!acc && g < 50);
          if (!acc) begin
            n_cmp++;
            n_bad++;
            $display("FAIL bp_drive_timeout: got no accept for beat %0d, expected accept", i);
          end
        end
        bus.in_valid = 1'b0;
      end
      begin
        int g;
        g = 0;
        do begin
          @(posedge clk); #1;
          g++;
        end while (!bus.out_valid && g < 50);
        if (!bus.out_valid) begin
          n_cmp++;
          n_bad++;
          $display("FAIL bp_out_timeout: got out_valid 0, expected 1");
        end
        bus.out_ready = 1'b0;
        @(negedge clk);
        held_a = bus.aout;
        held_b = bus.bout;
        for (int k = 0; k < 4; k++) begin
          if (k > 0) @(negedge clk);
          chk1("bp_in_ready", bus.in_ready, 1'b0);
          chk32("bp_aout_stable", bus.aout, held_a);
          chk32("bp_bout_stable", bus.bout, held_b);
          @(posedge clk); #1;
        end
        bus.out_ready = 1'b1;
      end
    join
    repeat (10) @(negedge clk);
    chk32("bp_count", n_out - base, 32'd5);
    chk32("bp_queue_empty", sb_q.size(), 32'd0);

    // Reset with three beats in flight.
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      drive(sa[i], sbv[i], stw[i], sinv[i], sscl[i]);
      bus.in_valid = 1'b1;
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk1("mid_rst_out_valid", bus.out_valid, 1'b0);
    chk1("mid_rst_sticky", bus.ovf_sticky, 1'b0);
    chk1("mid_rst_in_ready", bus.in_ready, 1'b1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk1("mid_rst_no_stale", bus.out_valid, 1'b0);
    end
    one_beat("post_rst", 32'h4000_2000, 32'h2000_E000, 32'h7FFF_0000, 0, 0,
             32'h6000_0000, 32'h2000_4000, 0);
    repeat (3) @(negedge clk);
    chk32("final_queue_empty", sb_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    n_bad++;
    $display("FAIL watchdog: got no completion by 200000, expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "watchdog expired");
  end

endmodule
